mic3_spi_responder: RTL and testbench

//  SPI responder that emulates the Pmod MIC3 ADC serial output: the peripheral end of the
//  MIC3 read interface, driven by our MIC3 SPI master. Each CS-low frame shifts out

---
 rtl/mic3_spi_responder.sv | 132 +++++++++++++
 tb/tb_mic3_spi_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mic3_spi_responder.sv
// Pmod MIC3 ADC emulator: SPI responder that shifts LEAD_ZEROS zeros then the held
// sample, MSB first, on each CS-low frame. SCLK and CS are oversampled in the clk domain.
module mic3_spi_responder #(
    parameter int DATA_BITS   = 12,
    parameter int LEAD_ZEROS  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] sample,
    input  logic                 sample_valid,
    input  logic                 SPI_SCLK,
    input  logic                 CS,
    output logic                 MISO,
    output logic                 miso_oe,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_abort,
    output logic                 stale
);
    localparam int FRAME_BITS = LEAD_ZEROS + DATA_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sclk_sync;
    logic [SYNC_STAGES-1:0]  cs_sync;
    logic [SYNC_STAGES-1:0]  sync_fill;
    logic                    sclk_d;
    logic                    cs_d;
    logic [DATA_BITS-1:0]    hold;
    logic                    fresh;
    logic                    armed;
    logic [FRAME_BITS-1:0]   shreg;
    logic [CNT_W-1:0]        bit_cnt;

    logic sclk_s, cs_s, sclk_fall, cs_fall, cs_rise, sync_ready;
    logic [FRAME_BITS-1:0] frame_word;

    assign sclk_s     = sclk_sync[SYNC_STAGES-1];
    assign cs_s       = cs_sync[SYNC_STAGES-1];
    assign sclk_fall  = sclk_d & ~sclk_s;
    assign cs_fall    = cs_d & ~cs_s;
    assign cs_rise    = ~cs_d & cs_s;
    // The reset value of the CS chain is not a real observation of the pin, so
    // arming waits until the chain has been refilled from the input.
    assign sync_ready = sync_fill[SYNC_STAGES-1];
    assign frame_word = FRAME_BITS'(hold);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sclk_sync   <= '1;
            cs_sync     <= '1;
            sync_fill   <= '0;
            sclk_d      <= 1'b1;
            cs_d        <= 1'b1;
            hold        <= '0;
            fresh       <= 1'b0;
            armed       <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            MISO        <= 1'b0;
            miso_oe     <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            stale       <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], SPI_SCLK};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], CS};
            sync_fill   <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
            sclk_d      <= sclk_s;
            cs_d        <= cs_s;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;

            if (cs_s && sync_ready)
                armed <= 1'b1;

            case (state)
                IDLE: begin
                    miso_oe <= 1'b0;
                    if (cs_fall && armed) begin
                        state   <= SHIFT;
                        shreg   <= frame_word;
                        MISO    <= frame_word[FRAME_BITS-1];
                        miso_oe <= 1'b1;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        stale   <= ~fresh;
                        fresh   <= 1'b0;
                        armed   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state       <= IDLE;
                        MISO        <= 1'b0;
                        miso_oe     <= 1'b0;
                        busy        <= 1'b0;
                        frame_abort <= 1'b1;
                    end else if (sclk_fall) begin
                        if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                            state      <= WAIT_CS;
                            MISO       <= 1'b0;
                            miso_oe    <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            shreg   <= shreg << 1;
                            bit_cnt <= bit_cnt + 1'b1;
                            MISO    <= shreg[FRAME_BITS-2];
                        end
                    end
                end
                WAIT_CS: begin
                    if (cs_rise)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A strobe coinciding with frame start refreshes the hold register for the next frame.
            if (sample_valid) begin
                hold  <= sample;
                fresh <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mic3_spi_responder.sv
// Bench for mic3_spi_responder: a bit-banged SPI master with a directed vector table,
// a reset-mid-frame sequence and randomized frames checked against a sample/freshness model.
module tb_mic3_spi_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] sample;
    logic        sample_valid;
    logic        SPI_SCLK;
    logic        CS;
    logic        MISO, miso_oe, busy, frame_done, frame_abort, stale;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int abort_cnt = 0;

    logic [11:0] m_hold;
    logic        m_fresh;

    typedef struct {
        logic        pre_sv;
        logic [11:0] pre_val;
        int          nbits;
        int          strobe_bit;
        logic [11:0] strobe_val;
        logic [15:0] exp_word;
        logic        exp_stale;
    } vec_t;

    vec_t vecs[7];

    mic3_spi_responder #(.DATA_BITS(12), .LEAD_ZEROS(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
        .SPI_SCLK(SPI_SCLK), .CS(CS), .MISO(MISO), .miso_oe(miso_oe), .busy(busy),
        .frame_done(frame_done), .frame_abort(frame_abort), .stale(stale)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done)  done_cnt  <= done_cnt + 1;
        if (frame_abort) abort_cnt <= abort_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic strobe(input logic [11:0] v);
        @(negedge clk);
        sample = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_frame(input int id, input int nbits, input int sb,
                             input logic [11:0] sv, input logic [15:0] exp_word,
                             input logic exp_stale);
        int d0, a0, nread;
        logic [15:0] rd;
        logic oe_bad, tail_bad;
        d0 = done_cnt; a0 = abort_cnt; rd = '0; oe_bad = 1'b0; tail_bad = 1'b0;
        CS = 1'b0;
        repeat (4) @(negedge clk);
        chk($sformatf("f%0d busy_start", id), busy, 1);
        for (int i = 0; i < nbits; i++) begin
            if (i < 16) begin
                rd = {rd[14:0], MISO};
                if (miso_oe !== 1'b1) oe_bad = 1'b1;
            end else if (miso_oe !== 1'b0) begin
                tail_bad = 1'b1;
            end
            SPI_SCLK = 1'b0;
            if (i == sb) begin
                @(negedge clk);
                sample = sv;
                sample_valid = 1'b1;
                @(negedge clk);
                sample_valid = 1'b0;
                repeat (2) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            if (i == 15) begin
                chk($sformatf("f%0d oe_after_16th_fall", id), miso_oe, 0);
                chk($sformatf("f%0d busy_after_16th_fall", id), busy, 0);
            end
            SPI_SCLK = 1'b1;
            repeat (4) @(negedge clk);
        end
        CS = 1'b1;
        repeat (8) @(negedge clk);
        nread = (nbits < 16) ? nbits : 16;
        chk($sformatf("f%0d word", id), rd, exp_word >> (16 - nread));
        chk($sformatf("f%0d oe_in_frame", id), oe_bad, 0);
        if (nbits > 16) chk($sformatf("f%0d tail_tristate", id), tail_bad, 0);
        chk($sformatf("f%0d stale", id), stale, exp_stale);
        chk($sformatf("f%0d done_pulses", id), done_cnt - d0, (nbits >= 16) ? 1 : 0);
        chk($sformatf("f%0d abort_pulses", id), abort_cnt - a0, (nbits < 16) ? 1 : 0);
        chk($sformatf("f%0d idle_oe", id), miso_oe, 0);
        chk($sformatf("f%0d idle_busy", id), busy, 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 12'hA5C, 16, -1, 12'h000, 16'h0A5C, 1'b0};
        vecs[1] = '{1'b0, 12'h000, 16, -1, 12'h000, 16'h0A5C, 1'b1};
        vecs[2] = '{1'b1, 12'hFFF, 16,  5, 12'h123, 16'h0FFF, 1'b0};
        vecs[3] = '{1'b0, 12'h000, 16, -1, 12'h000, 16'h0123, 1'b0};
        vecs[4] = '{1'b1, 12'h3C7,  7, -1, 12'h000, 16'h03C7, 1'b0};
        vecs[5] = '{1'b0, 12'h000, 16, -1, 12'h000, 16'h03C7, 1'b1};
        vecs[6] = '{1'b1, 12'h7E1, 20, -1, 12'h000, 16'h07E1, 1'b0};

        rst = 1'b1; CS = 1'b1; SPI_SCLK = 1'b1; sample = '0; sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset MISO", MISO, 0);
        chk("reset miso_oe", miso_oe, 0);
        chk("reset busy", busy, 0);
        chk("reset done/abort", {frame_done, frame_abort}, 0);
        chk("reset stale", stale, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].pre_sv) strobe(vecs[v].pre_val);
            run_frame(v, vecs[v].nbits, vecs[v].strobe_bit, vecs[v].strobe_val,
                      vecs[v].exp_word, vecs[v].exp_stale);
        end

        // Reset mid-frame, released while CS is still low.
        begin
            int d0;
            logic oe_seen;
            d0 = done_cnt; oe_seen = 1'b0;
            CS = 1'b0;
            repeat (4) @(negedge clk);
            for (int i = 0; i < 9; i++) begin
                SPI_SCLK = 1'b0; repeat (4) @(negedge clk);
                SPI_SCLK = 1'b1; repeat (4) @(negedge clk);
            end
            rst = 1'b1;
            #1;
            chk("rst_mid oe", miso_oe, 0);
            chk("rst_mid busy", busy, 0);
            chk("rst_mid MISO", MISO, 0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            repeat (8) @(negedge clk);
            for (int i = 0; i < 16; i++) begin
                if (miso_oe !== 1'b0) oe_seen = 1'b1;
                SPI_SCLK = 1'b0; repeat (4) @(negedge clk);
                if (miso_oe !== 1'b0) oe_seen = 1'b1;
                SPI_SCLK = 1'b1; repeat (4) @(negedge clk);
            end
            chk("rst_cs_low no_drive", oe_seen, 0);
            chk("rst_cs_low no_done", done_cnt - d0, 0);
            CS = 1'b1;
            repeat (8) @(negedge clk);
            run_frame(100, 16, -1, 12'h000, 16'h0000, 1'b1);
        end

        m_hold = '0;
        m_fresh = 1'b0;
        for (int r = 0; r < 20; r++) begin
            int nb, sb;
            logic [11:0] pv, sv;
            logic [15:0] ew;
            logic es;
            nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
            sb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
            pv = 12'($urandom);
            sv = 12'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                strobe(pv);
                m_hold = pv;
                m_fresh = 1'b1;
            end
            ew = {4'b0000, m_hold};
            es = ~m_fresh;
            m_fresh = 1'b0;
            if (sb >= 0) begin
                m_hold = sv;
                m_fresh = 1'b1;
            end
            run_frame(200 + r, nb, sb, sv, ew, es);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
